// File: rtl/dmem_responder.sv
// Data-memory responder: combinational loads, edge-registered stores, a show-ahead store log and a run checker.
// Load latency 0, store/log/checker 1 edge; a full log drops new stores and latches a sticky overflow flag.

module log_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic             pop_vld,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign pop_vld = (count != '0);
    assign full    = (count == (PW+1)'(DEPTH));
    assign do_pop  = pop && pop_vld;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);
    assign pop_dat = pop_vld ? store[rd_ptr] : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) store[wr_ptr] <= push_dat;
    end
endmodule

module dmem_responder #(
    parameter int DEPTH_WORDS = 64,
    parameter int LOG_DEPTH   = 8,
    parameter int PASS_ADR    = 100,
    parameter int PASS_DATA   = 7,
    parameter int TIMEOUT     = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    input  logic        log_pop,
    output logic        log_valid,
    output logic [31:0] log_adr,
    output logic [31:0] log_data,
    output logic        log_overflow,
    output logic        done,
    output logic        pass,
    output logic [15:0] cycles
);
    localparam int          AW           = $clog2(DEPTH_WORDS);
    localparam logic [31:0] MEM_BYTES    = 32'(4 * DEPTH_WORDS);
    localparam logic [31:0] PASS_ADR_W   = 32'(PASS_ADR);
    localparam logic [31:0] PASS_DATA_W  = 32'(PASS_DATA);
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
    } log_entry_t;

    typedef enum logic [1:0] {S_RUN, S_PASS, S_FAIL, S_TIMEOUT} state_t;

    logic [31:0] mem [DEPTH_WORDS];
    logic [AW-1:0] index;
    logic          in_range;
    logic          aligned;

    assign index    = DataAdr[AW+1:2];
    assign in_range = (DataAdr < MEM_BYTES);
    assign aligned  = (DataAdr[1:0] == 2'b00);
    assign ReadData = in_range ? mem[index] : 32'h0;

    always_ff @(posedge clock) begin
        if (MemWrite && aligned && in_range) mem[index] <= WriteData;
    end

    log_entry_t push_entry;
    log_entry_t head_entry;
    logic       log_full;

    assign push_entry = '{adr: DataAdr, dat: WriteData};

    log_fifo #(
        .WIDTH ($bits(log_entry_t)),
        .DEPTH (LOG_DEPTH)
    ) u_log (
        .clock    (clock),
        .reset    (reset),
        .push     (MemWrite),
        .push_dat (push_entry),
        .pop      (log_pop),
        .pop_vld  (log_valid),
        .pop_dat  (head_entry),
        .full     (log_full)
    );

    assign log_adr  = head_entry.adr;
    assign log_data = head_entry.dat;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                                           log_overflow <= 1'b0;
        else if (MemWrite && log_full && !(log_pop && log_valid)) log_overflow <= 1'b1;
    end

    state_t state;
    state_t state_nxt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_RUN;
        else       state <= state_nxt;
    end

    // An ordinary aligned store does not hold off the timeout; only PASS/FAIL stores pre-empt it.
    always_comb begin
        state_nxt = state;
        if (state == S_RUN) begin
            if (MemWrite && DataAdr == PASS_ADR_W)
                state_nxt = (WriteData == PASS_DATA_W) ? S_PASS : S_FAIL;
            else if (MemWrite && !aligned)
                state_nxt = S_FAIL;
            else if ({16'h0, cycles} == TIMEOUT_LAST)
                state_nxt = S_TIMEOUT;
        end
    end

    always_comb begin
        done = (state != S_RUN);
        pass = (state == S_PASS);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)                                     cycles <= 16'h0;
        else if (state == S_RUN && cycles != 16'hFFFF) cycles <= cycles + 16'h1;
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: store log entries queued at drive time and compared at the head.
module tb_dmem_responder;
    localparam int LD = 8;
    localparam int TO = 20;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        MemWrite = 1'b0;
    logic [31:0] DataAdr = 32'h0;
    logic [31:0] WriteData = 32'h0;
    logic        log_pop = 1'b0;
    logic [31:0] ReadData;
    logic        log_valid;
    logic [31:0] log_adr;
    logic [31:0] log_data;
    logic        log_overflow;
    logic        done;
    logic        pass;
    logic [15:0] cycles;

    dmem_responder #(
        .DEPTH_WORDS (64),
        .LOG_DEPTH   (LD),
        .PASS_ADR    (100),
        .PASS_DATA   (7),
        .TIMEOUT     (TO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .MemWrite     (MemWrite),
        .DataAdr      (DataAdr),
        .WriteData    (WriteData),
        .ReadData     (ReadData),
        .log_pop      (log_pop),
        .log_valid    (log_valid),
        .log_adr      (log_adr),
        .log_data     (log_data),
        .log_overflow (log_overflow),
        .done         (done),
        .pass         (pass),
        .cycles       (cycles)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
    } ent_t;

    ent_t        q[$];
    logic [31:0] mm [64];
    bit          mk [64];
    int          st;       // 0 run, 1 pass, 2 fail, 3 timeout
    int          cyc;
    bit          ovf;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        q.delete();
        st  = 0;
        cyc = 0;
        ovf = 0;
        check("rst_valid", 32'(log_valid), 0);
        check("rst_done", 32'(done), 0);
        check("rst_pass", 32'(pass), 0);
        check("rst_cycles", 32'(cycles), 0);
        check("rst_ovf", 32'(log_overflow), 0);
        check("rst_adr", log_adr, 0);
        check("rst_data", log_data, 0);
        #1;
        reset = 1'b0;
    endtask

    // One clock: drive inputs, check pre-edge values, update the model, check post-edge values.
    task automatic step(input bit we, input logic [31:0] adr, input logic [31:0] dat, input bit pop);
        int  idx;
        bit  known;
        idx = int'(adr[7:2]);
        MemWrite = we; DataAdr = adr; WriteData = dat; log_pop = pop;
        #1;
        known = (adr < 256) && mk[idx];
        if (we && known)     check("rdw_old", ReadData, mm[idx]);
        if (we && adr >= 256) check("rd_oob", ReadData, 0);
        if (pop) begin
            check("pop_valid", 32'(log_valid), 32'(q.size() > 0));
            if (q.size() > 0) begin
                check("pop_adr", log_adr, q[0].adr);
                check("pop_data", log_data, q[0].dat);
                void'(q.pop_front());
            end
        end
        if (we) begin
            if (q.size() < LD) q.push_back(ent_t'{adr, dat});
            else               ovf = 1;
        end
        if (we && adr[1:0] == 2'b00 && adr < 256) begin
            mm[idx] = dat;
            mk[idx] = 1;
        end
        if (st == 0) begin
            if (we && adr == 100)           st = (dat == 7) ? 1 : 2;
            else if (we && adr[1:0] != 0)   st = 2;
            else if (cyc == TO - 1)         st = 3;
            if (cyc < 65535) cyc++;
        end
        @(posedge clock);
        #1;
        MemWrite = 1'b0; log_pop = 1'b0;
        known = (adr < 256) && mk[idx];
        if (we && known) check("rdw_new", ReadData, mm[idx]);
        check("done", 32'(done), 32'(st != 0));
        check("pass", 32'(pass), 32'(st == 1));
        check("cycles", 32'(cycles), 32'(cyc));
        check("log_valid", 32'(log_valid), 32'(q.size() > 0));
        check("log_ovf", 32'(log_overflow), 32'(ovf));
        if (q.size() > 0) begin
            check("head_adr", log_adr, q[0].adr);
            check("head_data", log_data, q[0].dat);
        end
    endtask

    task automatic rd_check(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        DataAdr = adr;
        #1;
        check(tag, ReadData, exp);
    endtask

    task automatic drain();
        int n;
        n = q.size();
        for (int i = 0; i < n; i++) step(0, 32'h0, 32'h0, 1);
        check("drained", 32'(log_valid), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        #1;
        do_reset();

        // Basic loads/stores and in-order log
        step(1, 32'd0, 32'd17, 0);
        step(1, 32'd4, 32'd33, 0);
        rd_check("rd_4", 32'd4, 32'd33);
        rd_check("rd_0", 32'd0, 32'd17);
        rd_check("rd_400", 32'd400, 32'd0);
        step(1, 32'd4, 32'd99, 0);
        drain();

        // Pass at cycle 5, then frozen
        do_reset();
        for (int i = 0; i < 5; i++) step(0, 32'h0, 32'h0, 0);
        step(1, 32'd100, 32'd7, 0);
        check("pass_done", 32'(done), 1);
        check("pass_pass", 32'(pass), 1);
        check("pass_cycles", 32'(cycles), 6);
        for (int i = 0; i < 3; i++) step(0, 32'h0, 32'h0, 0);
        step(1, 32'd100, 32'd9, 0);
        check("pass_sticky", 32'(pass), 1);
        check("pass_frozen", 32'(cycles), 6);
        drain();

        // Wrong pass data, then misaligned store
        do_reset();
        step(1, 32'd100, 32'd8, 0);
        check("fail_done", 32'(done), 1);
        check("fail_pass", 32'(pass), 0);
        do_reset();
        step(1, 32'd12, 32'h1234, 0);
        step(1, 32'd15, 32'hDEAD, 0);
        check("mis_done", 32'(done), 1);
        rd_check("mis_mem", 32'd12, 32'h1234);
        drain();

        // Timeout with no stores
        do_reset();
        n = 0;
        while (!done && n < 40) begin
            step(0, 32'h0, 32'h0, 0);
            n++;
        end
        check("to_ticks", 32'(n), 20);
        check("to_cycles", 32'(cycles), 20);
        check("to_pass", 32'(pass), 0);

        // Overflow, then simultaneous push/pop while full
        do_reset();
        for (int i = 0; i < 9; i++) step(1, 32'(128 + 4 * i), 32'(i), 0);
        check("ovf_flag", 32'(log_overflow), 1);
        step(1, 32'd200, 32'hAA, 1);
        check("full_head", log_adr, 32'd132);
        drain();
        check("ovf_sticky", 32'(log_overflow), 1);

        // Reset mid-run with three entries logged
        do_reset();
        step(1, 32'd0, 32'h77, 0);
        step(1, 32'd4, 32'h88, 0);
        step(1, 32'd9, 32'h99, 0);
        check("pre_rst_done", 32'(done), 1);
        do_reset();
        rd_check("mem_kept", 32'd0, 32'h77);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder and store monitor for the single-cycle processor. It sits on the far end of the processor's data port (`MemWrite`, `DataAdr`, `WriteData`, `ReadData`), services loads and stores, logs every store into a FIFO the bench can drain, and runs a pass/fail/timeout checker. It replaces ad-hoc bench probing with a self-checking end of the data interface.

## Interface
Parameters:
- `DEPTH_WORDS`, 64: data memory size in 32-bit words; power of two.
- `LOG_DEPTH`, 8: store-log FIFO entries; power of two.
- `PASS_ADR`, 100: byte address of the completion store.
- `PASS_DATA`, 7: value at `PASS_ADR` that means pass.
- `TIMEOUT`, 1000: cycles allowed in RUN before TIMEOUT.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `MemWrite`  in  1  store strobe from the processor.
- `DataAdr`  in  32  byte address from the processor.
- `WriteData`  in  32  store data from the processor.
- `ReadData`  out  32  load data to the processor; combinational.
- `log_pop`  in  1  bench consumes the log head.
- `log_valid`  out  1  log is non-empty.
- `log_adr`  out  32  `DataAdr` of the head entry.
- `log_data`  out  32  `WriteData` of the head entry.
- `log_overflow`  out  1  sticky: a store was dropped because the log was full.
- `done`  out  1  checker is in a terminal state.
- `pass`  out  1  checker is in PASS.
- `cycles`  out  16  clocks spent in RUN; saturates at 16'hFFFF.

## Operation
- Word index is `DataAdr[log2(DEPTH_WORDS)+1:2]`.
- An address is in range when `DataAdr < 4*DEPTH_WORDS`.
- Memory: write on the clock edge when `MemWrite=1`, the address is aligned (`DataAdr[1:0]==0`) and in range. Otherwise memory is unchanged.
- Memory contents are not cleared by reset.
- `ReadData` = `mem[index]` if in range, else 0, whatever `DataAdr[1:0]` is.
- Log: every clock edge with `MemWrite=1` pushes {`DataAdr`, `WriteData`}. This includes misaligned and out-of-range stores, and stores made in any checker state.
- `log_adr`/`log_data` show the head entry (show-ahead) and are don't-care when `log_valid=0`.
- `log_pop` with `log_valid=1` removes the head. `log_pop` on an empty log is ignored.
- Push while full without a same-cycle pop: the entry is dropped, the FIFO is unchanged and `log_overflow` is set. `log_overflow` clears only on reset.
- Push while full with a same-cycle pop: both happen; occupancy stays at `LOG_DEPTH`.
- Read/write pointers wrap modulo `LOG_DEPTH`; an occupancy counter of width log2(`LOG_DEPTH`)+1 tells full from empty.
- Checker FSM states: RUN, PASS, FAIL, TIMEOUT. Transitions out of RUN, in priority order:
  - Store to `PASS_ADR` with data `PASS_DATA` -> PASS.
  - Store to `PASS_ADR` with other data, or any misaligned store -> FAIL.
  - `cycles == TIMEOUT-1` with no store -> TIMEOUT.
  - A qualifying store on the timeout cycle takes PASS/FAIL.
- PASS, FAIL and TIMEOUT are terminal until reset. Memory and log keep operating after a terminal state is reached.
- `done` = (state != RUN); `pass` = (state == PASS). Both are decoded from the state register.
- `cycles` increments on each edge while in RUN and freezes on leaving RUN.

## Timing
- Reset (asynchronous, immediate): state=RUN, `cycles`=0, log empty, `log_valid`=0, `log_overflow`=0, `done`=0, `pass`=0.
- `log_adr`/`log_data` are 0 while the log is empty after reset.
- `ReadData` has zero latency from `DataAdr`. Read-during-write at the same address returns the old word until the edge and the new word after it.
- A store on edge N: memory is updated, `log_valid` is high and `done`/`pass` reflect the store from edge N onward (one register stage, visible in cycle N+1).
- A pop on edge N: the next head (or `log_valid=0`) is shown after edge N.
- Reset asserted mid-operation: the log is flushed and the FSM returns to RUN immediately; memory contents are kept.

## Test plan
- Reset, then stores 17 -> addr 0, 33 -> addr 4, then `DataAdr`=4 -> `ReadData`=33, `DataAdr`=0 -> 17, `DataAdr`=400 -> 0. The log holds (0,17), (4,33) in order; popping twice clears `log_valid`.
- Store 7 -> addr 100 at cycle 5 -> `done`=1 and `pass`=1 the next cycle. `cycles` freezes at 6. A later store 9 -> addr 100 leaves `pass`=1.
- Store 8 -> addr 100 -> `done`=1, `pass`=0 (FAIL). Separate run: store to addr 15 -> FAIL, memory unchanged, entry (15, data) logged.
- No stores, `TIMEOUT`=20 -> `done`=1 and `pass`=0 after exactly 20 RUN cycles; `cycles`=20.
- 9 stores with no pops, `LOG_DEPTH`=8 -> 8 entries kept, the 9th dropped, `log_overflow`=1. Then push and pop in the same cycle while full -> occupancy stays 8 and the head advances.
- Assert `reset` between edges mid-run with 3 entries logged -> `log_valid`, `done` and `cycles` clear immediately; a previously stored word still reads back.
